// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// Table entries are {reg, val}; two reserved encodings drive control flow.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_HOLD,
    ST_SETTLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [15:0] CFG_END      = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_OP = 8'hF0;

  function automatic logic is_delay_entry(input logic [15:0] entry);
    return entry[15:8] == CFG_DELAY_OP;
  endfunction

endpackage

// File: rtl/cam_cfg_ms_timer.sv
// Millisecond down-counter shared by the power-up phases and delay entries.
// Reset preloads RST_MS so the reset-hold phase times from the first cycle.
module cam_cfg_ms_timer #(
  parameter int         MS_CYC = 25_000,
  parameter logic [7:0] RST_MS = 8'd5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expired
);

  localparam int            CW       = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(MS_CYC - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  logic [7:0]    ms_left;
  logic [CW-1:0] cyc;
  logic          period_end;

  assign period_end = (cyc == CYC_LAST);
  // Fires on the final cycle of the final millisecond, so a phase of N ms
  // occupies exactly N*MS_CYC cycles in the requesting state.
  assign expired    = (ms_left == 8'd1) && period_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_left <= RST_MS;
      cyc     <= '0;
    end else if (load) begin
      ms_left <= ms;
      cyc     <= '0;
    end else if (ms_left != 8'd0) begin
      if (period_end) begin
        cyc     <= '0;
        ms_left <= ms_left - 8'd1;
      end else begin
        cyc <= cyc + CYC_ONE;
      end
    end
  end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Power-sequences an SCCB sensor, then replays a register table through a
// byte-write master with inline delays, NACK retry and on-demand re-runs.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int         CLK_HZ    = 25_000_000,
  parameter logic [7:0] DEV_ADDR  = 8'h42,
  parameter int         TABLE_AW  = 8,
  parameter int         MAX_RETRY = 3,
  parameter int         PWRUP_MS  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic [TABLE_AW-1:0] tbl_idx,
  input  logic [15:0]         tbl_data,
  output logic                wr_req,
  output logic [7:0]          wr_dev,
  output logic [7:0]          wr_reg,
  output logic [7:0]          wr_val,
  input  logic                wr_ready,
  input  logic                wr_done,
  input  logic                wr_nack,
  output logic                cam_reset_n,
  output logic                cam_pwdn,
  output logic                done,
  output logic                error,
  output logic [TABLE_AW-1:0] err_idx,
  output state_t              dbg_state
);

  localparam int                  MS_CYC   = CLK_HZ / 1000;
  localparam logic [7:0]          PWR_MS8  = 8'(PWRUP_MS);
  localparam logic [3:0]          RETRY_MX = 4'(MAX_RETRY);
  localparam logic [TABLE_AW-1:0] IDX_LAST = '1;

  state_t     state;
  logic [3:0] retry;
  logic       tmr_load;
  logic [7:0] tmr_ms;
  logic       tmr_exp;
  logic       is_last;

  assign wr_dev    = DEV_ADDR;
  assign cam_pwdn  = 1'b0;
  assign dbg_state = state;
  assign is_last   = (tbl_idx == IDX_LAST);

  always_comb begin
    tmr_load = 1'b0;
    tmr_ms   = PWR_MS8;
    if (state == ST_HOLD) begin
      tmr_load = tmr_exp;
    end else if (state == ST_DECODE && tbl_data != CFG_END &&
                 is_delay_entry(tbl_data) && tbl_data[7:0] != 8'd0) begin
      tmr_load = 1'b1;
      tmr_ms   = tbl_data[7:0];
    end
  end

  cam_cfg_ms_timer #(
    .MS_CYC (MS_CYC),
    .RST_MS (PWR_MS8)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .ms      (tmr_ms),
    .expired (tmr_exp)
  );

  // Write handshake: a transfer happens on any clock where wr_req and
  // wr_ready are both high; wr_req drops on the next cycle and the fields
  // hold still from DECODE until then. wr_done/wr_nack count only in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_HOLD;
      tbl_idx     <= '0;
      wr_req      <= 1'b0;
      wr_reg      <= 8'd0;
      wr_val      <= 8'd0;
      cam_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_idx     <= '0;
      retry       <= 4'd0;
    end else begin
      case (state)
        ST_HOLD: if (tmr_exp) begin
          cam_reset_n <= 1'b1;
          state       <= ST_SETTLE;
        end
        ST_SETTLE: if (tmr_exp) begin
          tbl_idx <= '0;
          state   <= ST_FETCH;
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (tbl_data == CFG_END) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (is_delay_entry(tbl_data)) begin
            // A zero-length delay advances straight away.
            if (tbl_data[7:0] != 8'd0) state <= ST_DELAY;
            else if (is_last) begin done <= 1'b1; state <= ST_DONE; end
            else begin tbl_idx <= tbl_idx + 1'b1; state <= ST_FETCH; end
          end else begin
            wr_reg <= tbl_data[15:8];
            wr_val <= tbl_data[7:0];
            retry  <= 4'd0;
            wr_req <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (wr_ready) begin
          wr_req <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: if (wr_done) begin
          if (!wr_nack) begin
            if (is_last) begin done <= 1'b1; state <= ST_DONE; end
            else begin tbl_idx <= tbl_idx + 1'b1; state <= ST_FETCH; end
          end else if (retry < RETRY_MX) begin
            retry  <= retry + 4'd1;
            wr_req <= 1'b1;
            state  <= ST_ISSUE;
          end else begin
            err_idx <= tbl_idx;
            error   <= 1'b1;
            state   <= ST_FAIL;
          end
        end
        ST_DELAY: if (tmr_exp) begin
          if (is_last) begin done <= 1'b1; state <= ST_DONE; end
          else begin tbl_idx <= tbl_idx + 1'b1; state <= ST_FETCH; end
        end
        ST_DONE, ST_FAIL: if (start) begin
          done    <= 1'b0;
          error   <= 1'b0;
          err_idx <= '0;
          tbl_idx <= '0;
          state   <= ST_FETCH;
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: doc/cam_cfg_sequencer.md
# cam_cfg_sequencer

Parametrised camera configuration sequencer. It power-sequences an SCCB image sensor (OV7670 family), then walks a register table, issuing one SCCB write per entry through a byte-write master. It adds inline delay entries, NACK retry with error reporting, and on-demand re-runs. It sits between the sensor pins and the capture path; `done` gates capture start.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: core clock frequency; `MS_CYC = CLK_HZ/1000` cycles per millisecond.
- `DEV_ADDR`, 8'h42: SCCB write address (7-bit 0x21 plus write bit).
- `TABLE_AW`, 8: table index width; depth is 2^TABLE_AW entries.
- `MAX_RETRY`, 3: re-issues allowed per entry after a NACK; range 0..15.
- `PWRUP_MS`, 5: duration of the reset-hold phase and of the settle phase, in ms; range 1..255.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle re-run request; honoured only in DONE or FAIL.
- `tbl_idx` out TABLE_AW: table read address.
- `tbl_data` in 16: entry `{reg[15:8], val[7:0]}`; valid one cycle after `tbl_idx` changes (synchronous ROM).
- `wr_req` out 1: write request to the SCCB master.
- `wr_dev`, `wr_reg`, `wr_val` out 8 each: write fields; stable while `wr_req` is high.
- `wr_ready` in 1: master accepts the request this cycle.
- `wr_done` in 1: single-cycle pulse; the transaction has finished.
- `wr_nack` in 1: valid with `wr_done`; high means the slave did not acknowledge.
- `cam_reset_n` out 1: sensor reset, active low.
- `cam_pwdn` out 1: sensor power-down, active high.
- `done` out 1: table completed successfully; level.
- `error` out 1: retries exhausted; level.
- `err_idx` out TABLE_AW: index of the failing entry.

## Operation
- Reset values: `cam_reset_n=0`, `cam_pwdn=0`, `wr_req=0`, `wr_dev=DEV_ADDR`, `wr_reg=0`, `wr_val=0`, `tbl_idx=0`, `done=0`, `error=0`, `err_idx=0`. The state is HOLD.
- HOLD: `cam_reset_n=0` for `PWRUP_MS*MS_CYC` cycles, then go to SETTLE.
- SETTLE: `cam_reset_n=1` for `PWRUP_MS*MS_CYC` cycles, then go to FETCH with index 0.
- FETCH: drive `tbl_idx` and wait 1 cycle, then go to DECODE.
- DECODE, by `tbl_data`:
  - 16'hFFFF: end marker; go to DONE.
  - 8'hF0 in the high byte: delay entry; go to DELAY for `val*MS_CYC` cycles. `val=0` means no wait.
  - Anything else: latch `wr_reg`/`wr_val`, clear the retry count, go to ISSUE.
- ISSUE: assert `wr_req` and hold it until `wr_ready` is sampled high. `wr_req` drops the following cycle. Go to WAIT.
- WAIT: on `wr_done`:
  - `wr_nack=0`: advance.
  - `wr_nack=1` and retry count < MAX_RETRY: increment the count and return to ISSUE.
  - Otherwise: latch `err_idx`, go to FAIL.
- Advance: if the index is the last (2^TABLE_AW−1), go to DONE because the table is implicitly terminated. Otherwise increment the index and go to FETCH.
- DONE: `done=1`. FAIL: `error=1`. Both are terminal until `start`.
- `start` in DONE or FAIL: clear `done`, `error` and `err_idx`, then go to FETCH with index 0. There is no power re-sequence. `start` in any other state is ignored.
- `cam_pwdn` is held at 0 in every state.
- `reset_n` asserted mid-transaction: all outputs return to reset values immediately and the sequence restarts from HOLD. The SCCB master shares the same reset.
- A `wr_done` pulse arriving outside WAIT is ignored.

## Timing
- The ms counter is cleared on entry to HOLD, SETTLE and DELAY. Each phase lasts exactly N*MS_CYC cycles; there is no free-running tick.
- Entry overhead: 2 cycles (FETCH + DECODE) before ISSUE or DELAY.
- `wr_req` may rise in the same cycle as `wr_ready`. The transfer completes that cycle.
- Write fields change only in DECODE, never while `wr_req` is high.
- `done` and `error` assert 1 cycle after the deciding event, and are mutually exclusive.
- Total writes per entry are at most MAX_RETRY+1.

## Structure
- Shared package `cam_cfg_pkg`:
  - State enum: HOLD, SETTLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE, FAIL.
  - Constants `CFG_END=16'hFFFF` and `CFG_DELAY_OP=8'hF0`.
- Sub-module `cam_cfg_ms_timer`: loads an 8-bit ms count, counts `MS_CYC`-cycle periods, and pulses `expired`. It is shared by HOLD, SETTLE and DELAY.
- The table ROM and SCCB master are external.

## Test plan
- CLK_HZ=10_000, PWRUP_MS=2, table {1280,1180,FFFF}:
  - `cam_reset_n` is low for 20 cycles, then high for 20 cycles.
  - Writes occur as (0x12,0x80) then (0x11,0x80), each with `wr_dev=0x42`.
  - `done` rises after the second `wr_done`.
- Table {F003,3A04,FFFF} at MS_CYC=10: exactly 30 cycles of DELAY pass before `wr_req` for 0x3A.
- `wr_nack=1` on the first two attempts of entry 1, MAX_RETRY=3: three writes of the same fields, then `done=1` and `error=0`.
- `wr_nack` always 1 on entry 2, MAX_RETRY=2: three attempts, then `error=1`, `err_idx=2`, `done=0`. A later `start` re-runs from index 0 with no HOLD phase.
- TABLE_AW=2 with no end marker: four writes, then `done=1`, and `tbl_idx` never wraps to 0.
- `wr_ready` delayed 5 cycles: `wr_req` and its fields are stable throughout. `reset_n` pulsed low during WAIT: all outputs return to reset values at once and the sequence restarts from HOLD.
